// File: rtl/bht_update_ctrl_if.sv
// Bundles the update queue, fetch lookup, history-array and PHT buses of bht_update_ctrl.
// slave = controller side, master = environment side (EX, fetch, arrays).
interface bht_update_ctrl_if #(
    parameter int IDX_W  = 4,
    parameter int HIST_W = 5
);
    logic              upd_valid;
    logic              upd_ready;
    logic [IDX_W-1:0]  upd_index;
    logic              upd_taken;
    logic              upd_mispred;
    logic              lk_valid;
    logic [IDX_W-1:0]  lk_index;
    logic [HIST_W-1:0] lk_hist;
    logic              lk_stall;
    logic              hist_read;
    logic [IDX_W-1:0]  hist_rindex;
    logic [HIST_W-1:0] hist_data;
    logic              hist_shift;
    logic [IDX_W-1:0]  hist_windex;
    logic              hist_shift_in;
    logic [HIST_W-1:0] pht_raddr;
    logic [1:0]        pht_rdata;
    logic              pht_we;
    logic [1:0]        pht_wdata;

    modport slave (
        input  upd_valid, upd_index, upd_taken, upd_mispred, lk_valid, lk_index,
               hist_data, pht_rdata,
        output upd_ready, lk_hist, lk_stall, hist_read, hist_rindex, hist_shift,
               hist_windex, hist_shift_in, pht_raddr, pht_we, pht_wdata
    );

    modport master (
        output upd_valid, upd_index, upd_taken, upd_mispred, lk_valid, lk_index,
               hist_data, pht_rdata,
        input  upd_ready, lk_hist, lk_stall, hist_read, hist_rindex, hist_shift,
               hist_windex, hist_shift_in, pht_raddr, pht_we, pht_wdata
    );
endinterface

// File: rtl/bht_update_ctrl.sv
// BHT update sequencer: queues branch resolutions and retires each as history read, PHT RMW and
// history shift, sharing the history read port with fetch. Define BHT_PERF_EN for perf counters.
module bht_update_ctrl #(
    parameter int IDX_W      = 4,
    parameter int HIST_W     = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bht_update_ctrl_if.slave bus
`ifdef BHT_PERF_EN
    ,
    output logic [31:0]      perf_upd_cnt_o,
    output logic [31:0]      perf_mispred_cnt_o
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_RDH, S_WR} state_e;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             taken;
        logic             mispred;
    } upd_t;

    state_e            state_q, state_d;
    upd_t              q_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [HIST_W-1:0] hreg_q;
    upd_t              head;
    logic              push, pop, empty, starved;

    assign head    = q_mem_q[rd_ptr_q];
    assign empty   = (cnt_q == '0);
    assign starved = (starve_q == SC_W'(STARVE_MAX));
    assign push    = bus.upd_valid && bus.upd_ready;
    assign pop     = (state_q == S_WR);
    assign cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);

    assign bus.upd_ready     = (cnt_q != CNT_W'(DEPTH));
    assign bus.hist_windex   = head.index;
    assign bus.hist_shift_in = head.taken;
    assign bus.pht_raddr     = hreg_q;

    // Saturating 2-bit counter update for the head entry's direction.
    always_comb begin
        bus.pht_wdata = bus.pht_rdata;
        if (head.taken) begin
            if (bus.pht_rdata != 2'b11) bus.pht_wdata = bus.pht_rdata + 2'b01;
        end else begin
            if (bus.pht_rdata != 2'b00) bus.pht_wdata = bus.pht_rdata - 2'b01;
        end
    end

    always_comb begin
        state_d         = state_q;
        starve_d        = starve_q;
        bus.hist_read   = 1'b0;
        bus.hist_rindex = bus.lk_index;
        bus.lk_hist     = '0;
        bus.lk_stall    = 1'b0;
        bus.hist_shift  = 1'b0;
        bus.pht_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && (!bus.lk_valid || starved)) begin
                    state_d  = S_RDH;
                    starve_d = '0;
                end else if (!empty && bus.lk_valid) begin
                    starve_d = starve_q + SC_W'(1);
                end
            end
            S_RDH: state_d = S_WR;
            S_WR: begin
                state_d        = S_IDLE;
                bus.pht_we     = 1'b1;
                bus.hist_shift = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // The update owns the read port only in S_RDH; any fetch then replays.
        if (state_q == S_RDH) begin
            bus.hist_read   = 1'b1;
            bus.hist_rindex = head.index;
            bus.lk_stall    = bus.lk_valid;
        end else if (bus.lk_valid) begin
            bus.hist_read = 1'b1;
            bus.lk_hist   = bus.hist_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            hreg_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (state_q == S_RDH) hreg_q <= bus.hist_data;
        end
    end

    // Entry storage is only meaningful below cnt_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) q_mem_q[wr_ptr_q] <= '{index: bus.upd_index, taken: bus.upd_taken,
                                         mispred: bus.upd_mispred};
    end

`ifdef BHT_PERF_EN
    logic [31:0] perf_upd_q, perf_mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_upd_q <= '0;
            perf_mis_q <= '0;
        end else if (pop) begin
            perf_upd_q <= perf_upd_q + 32'd1;
            if (head.mispred) perf_mis_q <= perf_mis_q + 32'd1;
        end
    end

    assign perf_upd_cnt_o     = perf_upd_q;
    assign perf_mispred_cnt_o = perf_mis_q;
`endif
endmodule

// File: tb/tb_bht_update_ctrl.sv
// Scoreboard bench for bht_update_ctrl: directed updates queue their expected PHT/history writes,
// a negedge monitor checks every write the DUT issues; history and PHT arrays are modelled here.
module tb_bht_update_ctrl;
    localparam int IDX_W      = 4;
    localparam int HIST_W     = 5;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic              sin;
        logic [HIST_W-1:0] addr;
        logic [1:0]        wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bht_update_ctrl_if #(.IDX_W(IDX_W), .HIST_W(HIST_W)) bus ();

`ifdef BHT_PERF_EN
    logic [31:0] perf_upd, perf_mis;
`endif

    bht_update_ctrl #(.IDX_W(IDX_W), .HIST_W(HIST_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst_n (rst_n),
        .bus (bus)
`ifdef BHT_PERF_EN
        ,
        .perf_upd_cnt_o (perf_upd),
        .perf_mispred_cnt_o (perf_mis)
`endif
    );

    logic [HIST_W-1:0] hist_mem [2**IDX_W];
    logic [1:0]        pht_mem  [2**HIST_W];
    logic              pre_clr, pre_we;
    logic [IDX_W-1:0]  pre_h_idx;
    logic [HIST_W-1:0] pre_h_val, pre_p_idx;
    logic [1:0]        pre_p_val;

    assign bus.hist_data = hist_mem[bus.hist_rindex];
    assign bus.pht_rdata = pht_mem[bus.pht_raddr];

    always @(posedge clk) begin
        if (pre_clr) begin
            for (int i = 0; i < 2**IDX_W; i++) hist_mem[i] <= '0;
            for (int j = 0; j < 2**HIST_W; j++) pht_mem[j] <= '0;
        end else begin
            if (bus.hist_shift)
                hist_mem[bus.hist_windex] <= {hist_mem[bus.hist_windex][HIST_W-2:0], bus.hist_shift_in};
            if (bus.pht_we) pht_mem[bus.pht_raddr] <= bus.pht_wdata;
            if (pre_we) begin
                hist_mem[pre_h_idx] <= pre_h_val;
                pht_mem[pre_p_idx]  <= pre_p_val;
            end
        end
    end

    exp_t exp_q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every PHT write / history shift must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.pht_we || bus.hist_shift) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: idx %0d addr %0d wdata %0b", bus.hist_windex,
                         bus.pht_raddr, bus.pht_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("we_shift_pair", 32'({bus.pht_we, bus.hist_shift}), 32'(2'b11));
                chk("hist_windex", 32'(bus.hist_windex), 32'(mon_e.idx));
                chk("hist_shift_in", 32'(bus.hist_shift_in), 32'(mon_e.sin));
                chk("pht_raddr", 32'(bus.pht_raddr), 32'(mon_e.addr));
                chk("pht_wdata", 32'(bus.pht_wdata), 32'(mon_e.wd));
            end
        end
    end

    task automatic preload(input logic [IDX_W-1:0] hi, input logic [HIST_W-1:0] hv,
                           input logic [HIST_W-1:0] pi, input logic [1:0] pv);
        pre_we = 1'b1; pre_h_idx = hi; pre_h_val = hv; pre_p_idx = pi; pre_p_val = pv;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic upd(input logic [IDX_W-1:0] idx, input logic tk, input logic mis,
                       input logic [HIST_W-1:0] addr, input logic [1:0] wd, input bit expect_wr);
        chk("upd_ready_at_push", 32'(bus.upd_ready), 32'd1);
        bus.upd_valid = 1'b1; bus.upd_index = idx; bus.upd_taken = tk; bus.upd_mispred = mis;
        if (expect_wr) exp_q.push_back('{idx: idx, sin: tk, addr: addr, wd: wd});
        @(posedge clk); #1;
        bus.upd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc;
        bus.upd_valid = 1'b0; bus.upd_index = '0; bus.upd_taken = 1'b0; bus.upd_mispred = 1'b0;
        bus.lk_valid = 1'b0; bus.lk_index = '0;
        pre_we = 1'b0; pre_h_idx = '0; pre_h_val = '0; pre_p_idx = '0; pre_p_val = '0;
        pre_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pre_clr = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_upd_ready", 32'(bus.upd_ready), 32'd1);
        chk("rst_lk_stall", 32'(bus.lk_stall), 32'd0);
        chk("rst_hist_shift", 32'(bus.hist_shift), 32'd0);
        chk("rst_pht_we", 32'(bus.pht_we), 32'd0);
        chk("rst_hist_read", 32'(bus.hist_read), 32'd0);

        // Single update: hist 00101 addresses pht[5]=01, taken -> 10.
        preload(4'd3, 5'b00101, 5'd5, 2'b01);
        upd(4'd3, 1'b1, 1'b0, 5'd5, 2'b10, 1'b1);
        @(posedge clk); #1;
        chk("t1_rdh_read", 32'(bus.hist_read), 32'd1);
        chk("t1_rdh_rindex", 32'(bus.hist_rindex), 32'd3);
        wait_drain(10);
        chk("t1_hist3", 32'(hist_mem[3]), 32'(5'b01011));

        // Saturation at both ends.
        preload(4'd2, 5'b01010, 5'd10, 2'b11);
        upd(4'd2, 1'b1, 1'b0, 5'd10, 2'b11, 1'b1);
        wait_drain(10);
        preload(4'd4, 5'b00011, 5'd3, 2'b00);
        upd(4'd4, 1'b0, 1'b0, 5'd3, 2'b00, 1'b0 | 1'b1);
        wait_drain(10);

        // Fill with fetch holding the port; the same pht[0] counter climbs and saturates.
        preload(4'd1, 5'b10001, 5'd0, 2'b00);
        preload(4'd8, 5'd0, 5'd0, 2'b00);
        preload(4'd9, 5'd0, 5'd0, 2'b00);
        preload(4'd10, 5'd0, 5'd0, 2'b00);
        preload(4'd11, 5'd0, 5'd0, 2'b00);
        bus.lk_valid = 1'b1; bus.lk_index = 4'd1;
        upd(4'd8, 1'b1, 1'b0, 5'd0, 2'b01, 1'b1);
        upd(4'd9, 1'b1, 1'b0, 5'd0, 2'b10, 1'b1);
        upd(4'd10, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1);
        upd(4'd11, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1);
        chk("t3_full_ready", 32'(bus.upd_ready), 32'd0);
        chk("t3_lk_hist", 32'(bus.lk_hist), 32'(5'b10001));
        chk("t3_no_stall_yet", 32'(bus.lk_stall), 32'd0);
        ncyc = 0;
        while (!bus.lk_stall && ncyc < 40) begin
            @(posedge clk); #1;
            ncyc++;
        end
        // Granted fetch cycles with the queue non-empty: 8 counting up plus the deciding cycle.
        chk("t3_starve_cycles", 32'(ncyc + 3), 32'(STARVE_MAX + 1));
        chk("t3_stall_lk_hist", 32'(bus.lk_hist), 32'd0);
        chk("t3_stall_rindex", 32'(bus.hist_rindex), 32'd8);
        @(posedge clk); #1;
        chk("t3_stall_one_cycle", 32'(bus.lk_stall), 32'd0);
        chk("t3_wr_lk_hist", 32'(bus.lk_hist), 32'(5'b10001));
        @(posedge clk); #1;
        chk("t3_ready_after_pop", 32'(bus.upd_ready), 32'd1);
        bus.lk_valid = 1'b0;
        wait_drain(40);
        chk("t3_hist8", 32'(hist_mem[8]), 32'(5'b00001));

        // Back-to-back same index: second access sees the shifted history.
        preload(4'd7, 5'd0, 5'd0, 2'b01);
        preload(4'd0, 5'd0, 5'd1, 2'b10);
        upd(4'd7, 1'b1, 1'b0, 5'd0, 2'b10, 1'b1);
        upd(4'd7, 1'b0, 1'b0, 5'd1, 2'b01, 1'b1);
        wait_drain(20);
        chk("t4_hist7", 32'(hist_mem[7]), 32'(5'b00010));

        // Reset while in S_RDH with three queued: everything is discarded.
        bus.lk_valid = 1'b1; bus.lk_index = 4'd0;
        upd(4'd12, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0);
        upd(4'd13, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0);
        upd(4'd14, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0);
        bus.lk_valid = 1'b0;
        @(posedge clk); #1;
        chk("t5_in_rdh_read", 32'(bus.hist_read), 32'd1);
        chk("t5_in_rdh_rindex", 32'(bus.hist_rindex), 32'd12);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(bus.upd_ready), 32'd1);
        chk("t5_rst_hist_read", 32'(bus.hist_read), 32'd0);
        chk("t5_rst_pht_we", 32'(bus.pht_we), 32'd0);
        chk("t5_rst_shift", 32'(bus.hist_shift), 32'd0);
        chk("t5_rst_stall", 32'(bus.lk_stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("t5_ready_after", 32'(bus.upd_ready), 32'd1);
        chk("t5_hist12_untouched", 32'(hist_mem[12]), 32'd0);

        // Five updates, two mispredicted, through one PHT counter.
        preload(4'd0, 5'd0, 5'd0, 2'b00);
        preload(4'd1, 5'd0, 5'd0, 2'b00);
        preload(4'd2, 5'd0, 5'd0, 2'b00);
        preload(4'd3, 5'd0, 5'd0, 2'b00);
        preload(4'd4, 5'd0, 5'd0, 2'b00);
        upd(4'd0, 1'b1, 1'b1, 5'd0, 2'b01, 1'b1);
        upd(4'd1, 1'b1, 1'b0, 5'd0, 2'b10, 1'b1);
        upd(4'd2, 1'b1, 1'b1, 5'd0, 2'b11, 1'b1);
        upd(4'd3, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1);
        upd(4'd4, 1'b1, 1'b0, 5'd0, 2'b11, 1'b1);
        wait_drain(40);
`ifdef BHT_PERF_EN
        chk("t6_perf_upd", perf_upd, 32'd5);
        chk("t6_perf_mispred", perf_mis, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
